// File: rtl/dm_bus_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
package dm_bus_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned BE_W                = DATA_W / 8;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned ADDR_IDX_W          = $clog2(DEFAULT_DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dm_req_t;

  // Misaligned, or outside the window; addresses below base wrap to huge offsets.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       depth);
    logic [ADDR_W+1:0] off;
    logic [ADDR_W+1:0] lim;
    off = {2'b00, addr - base};
    lim = (ADDR_W+2)'(depth) << 2;
    return (addr[1:0] != 2'b00) || (off >= lim);
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dm_word_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_bus_responder.sv
// Responder end of the CPU data-memory interface: fixed-latency load/store
// with address-error reporting over valid/ready request and response channels.
module dm_bus_responder
  import dm_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  dm_req_t           req_q;
  logic              err_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              busy_q;

  dm_req_t           req_in_c;
  logic              accept_c;
  logic              final_wait_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [IDX_W-1:0]  lat_idx_c;
  logic [IDX_W-1:0]  ram_addr_c;
  logic              ram_en_c;
  logic              ram_we_c;
  logic [31:0]       ram_rdata;

  assign req_in_c = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign accept_c = (state_q == IDLE) && req_valid && req_ready_q;
  assign final_wait_c = (state_q == WAIT) && (cnt_q == '0);

  assign req_idx_c = IDX_W'((req_addr - BASE_ADDR) >> 2);
  assign lat_idx_c = IDX_W'((req_q.addr - BASE_ADDR) >> 2);

  // The RAM reads every cycle outside RESP; the read issued on the edge that
  // enters the final WAIT cycle lands in time for the WAIT->RESP edge. In IDLE
  // the live request address is used so LATENCY=1 still gets its read.
  always_comb begin
    ram_addr_c = lat_idx_c;
    ram_we_c   = 1'b0;
    ram_en_c   = 1'b0;
    if (state_q == IDLE) begin
      ram_addr_c = req_idx_c;
    end
    if (state_q != RESP) begin
      ram_en_c = 1'b1;
    end
    if (final_wait_c && req_q.we && !err_q) begin
      ram_we_c = 1'b1;
    end
  end

  dm_word_ram #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en_c),
    .we_i    (ram_we_c),
    .be_i    (req_q.be),
    .addr_i  (ram_addr_c),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            req_q       <= req_in_c;
            err_q       <= addr_err(req_addr, BASE_ADDR, DEPTH_WORDS);
            cnt_q       <= CNT_W'(LATENCY - 1);
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            resp_rdata_q <= (err_q || req_q.we) ? 32'h0 : ram_rdata;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Self-checking bench for dm_bus_responder: vector table plus scoreboard.
module tb_dm_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  dm_bus_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, sb_e.rdata);
        chk("resp_err", 32'(resp_err), 32'(sb_e.err));
      end
    end
  end

  // Drive one request, push its expectation, and measure accept-to-valid latency.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    bit ok;
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom());
    req_addr  = $urandom();
    req_wdata = $urandom();
    req_be    = 4'($urandom());
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("resp_latency", 32'(n), 32'd2);
  endtask

  task automatic finish_resp();
    @(posedge clk);
    #1;
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'hFF22_FF44, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h0000_1000, 32'hCAFE_BABE, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0BAD_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h55AA_1234, 4'hF, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h55AA_1234, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[14] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 32'h0000_0008, 32'h0,         4'h3, 32'h1234_5678, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
      finish_resp();
    end

    // Backpressure: response must hold and no request may be taken.
    resp_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_resp_err", 32'(resp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      req_valid = (i == 2);
      req_we    = 1'b1;
      req_addr  = 32'h0000_0010;
      req_wdata = 32'h0000_0000;
      req_be    = 4'hF;
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    finish_resp();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    finish_resp();

    // Reset in WAIT: the pending store must not commit.
    chk("rw_pre_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0008;
    req_wdata = 32'hA5A5_A5A5;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rw_accepted_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_rdata", resp_rdata, 32'd0);
    chk("rw_resp_err", 32'(resp_err), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    finish_resp();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
